// File: rtl/rf_wr_arbiter_if.sv
// Producer-side bundle of the shared register-file write port: the request
// triples coming in, and the ack, write strobe and stall hint going out.
interface rf_wr_arbiter_if #(
  parameter int NUM_REQ       = 4,
  parameter int reg_sel_width = 5,
  parameter int data_width    = 32
);
  // Handshake: producer i raises req[i] with req_sel/req_data slice i and holds
  // all three stable until it samples ack[i]=1 (a one-cycle pulse); the write
  // is then committed, and the producer may drop req or present its next write.
  logic [NUM_REQ-1:0]               req;
  logic [NUM_REQ*reg_sel_width-1:0] req_sel;
  logic [NUM_REQ*data_width-1:0]    req_data;
  logic [NUM_REQ-1:0]               ack;
  logic                             rf_wr_en;
  logic [reg_sel_width-1:0]         rf_wr_sel;
  logic [data_width-1:0]            rf_wr_data;
  logic                             pending;

  modport master (
    output req, req_sel, req_data,
    input  ack, rf_wr_en, rf_wr_sel, rf_wr_data, pending
  );

  modport slave (
    input  req, req_sel, req_data,
    output ack, rf_wr_en, rf_wr_sel, rf_wr_data, pending
  );
endinterface

// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between
// NUM_REQ producers; one registered write (and ack pulse) per cycle at most.
module rf_wr_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int reg_sel_width = 5,
  parameter int data_width    = 32
) (
  input  logic          clk,
  input  logic          rst,
  rf_wr_arbiter_if.slave bus,
  output logic          dbg_state_o
);
  localparam int PTR_W = $clog2(NUM_REQ);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;

  logic [NUM_REQ-1:0]       ack_q, ack_d;
  logic [NUM_REQ-1:0]       elig;
  logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]         win;
  logic                     found;
  int unsigned              idx;
  logic                     rf_wr_en_q, rf_wr_en_d;
  logic [reg_sel_width-1:0] sel_w, sel_q, sel_d;
  logic [data_width-1:0]    data_w, data_q, data_d;
  logic [0:0]               state_q, state_d;

  // A request being acked this cycle still shows req high; masking it with
  // the registered ack keeps the same write from being granted twice.
  assign elig = bus.req & ~ack_q;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && elig[PTR_W'(idx)]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
  end

  assign sel_w  = bus.req_sel[int'(win)*reg_sel_width +: reg_sel_width];
  assign data_w = bus.req_data[int'(win)*data_width +: data_width];

  always_comb begin
    ack_d      = '0;
    rr_ptr_d   = rr_ptr_q;
    rf_wr_en_d = 1'b0;
    sel_d      = sel_q;
    data_d     = data_q;
    state_d    = ST_IDLE;
    if (found) begin
      ack_d[win] = 1'b1;
      rr_ptr_d   = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      // Writes to x0 are acked but never strobed into the regfile.
      rf_wr_en_d = (sel_w != '0);
      sel_d      = sel_w;
      data_d     = data_w;
      state_d    = ST_WRITE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ack_q      <= '0;
      rr_ptr_q   <= '0;
      rf_wr_en_q <= 1'b0;
      sel_q      <= '0;
      data_q     <= '0;
      state_q    <= ST_IDLE;
    end else begin
      ack_q      <= ack_d;
      rr_ptr_q   <= rr_ptr_d;
      rf_wr_en_q <= rf_wr_en_d;
      sel_q      <= sel_d;
      data_q     <= data_d;
      state_q    <= state_d;
    end
  end

  assign bus.ack        = ack_q;
  assign bus.rf_wr_en   = rf_wr_en_q;
  assign bus.rf_wr_sel  = sel_q;
  assign bus.rf_wr_data = data_q;
  assign bus.pending    = |(bus.req & ~ack_q);
  assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Bench for rf_wr_arbiter: directed scenarios with literal expectations, then
// random producers checked every cycle against a behavioural model.
module tb_rf_wr_arbiter;
  localparam int N  = 4;
  localparam int SW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dbg_state;

  always #5 clk = ~clk;

  rf_wr_arbiter_if #(.NUM_REQ(N), .reg_sel_width(SW), .data_width(DW)) bus ();

  rf_wr_arbiter #(.NUM_REQ(N), .reg_sel_width(SW), .data_width(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Model state: expected registered outputs and the round-robin pointer
  logic [N-1:0]       e_ack  = '0;
  logic               e_en   = 1'b0;
  logic [SW-1:0]      e_sel  = '0;
  logic [DW-1:0]      e_data = '0;
  int                 m_ptr  = 0;
  int                 waited [N];
  logic [SW+DW-1:0]   exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_p(input int i, input logic [SW-1:0] s, input logic [DW-1:0] d);
    bus.req_sel[i*SW +: SW]  = s;
    bus.req_data[i*DW +: DW] = d;
    bus.req[i]               = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b0;
    bus.req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Behavioural model: winner is the eligible producer closest at/after the pointer
  initial begin : model
    logic [N-1:0] el;
    int best, bestd, d;
    for (int i = 0; i < N; i++) waited[i] = 0;
    forever begin
      @(posedge clk);
      if (!rst) begin
        e_ack = '0; e_en = 1'b0; e_sel = '0; e_data = '0; m_ptr = 0;
        exp_q.delete();
        for (int i = 0; i < N; i++) waited[i] = 0;
      end else begin
        el    = bus.req & ~e_ack;
        best  = -1;
        bestd = N;
        for (int i = 0; i < N; i++) begin
          if (el[i]) begin
            d = (i - m_ptr + N) % N;
            if (d < bestd) begin bestd = d; best = i; end
          end
        end
        e_ack = '0;
        e_en  = 1'b0;
        if (best >= 0) begin
          e_ack[best] = 1'b1;
          e_sel  = bus.req_sel[best*SW +: SW];
          e_data = bus.req_data[best*DW +: DW];
          e_en   = (e_sel != 0);
          m_ptr  = (best + 1) % N;
          if (e_en) exp_q.push_back({e_sel, e_data});
        end
        for (int i = 0; i < N; i++) begin
          if (i == best) begin
            chk("fairness", 64'(waited[i] < N), 64'd1);
            waited[i] = 0;
          end else if (el[i] && best >= 0) waited[i]++;
          else if (!el[i]) waited[i] = 0;
        end
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model, plus write scoreboard
  initial begin : compare
    logic [SW+DW-1:0] got;
    forever begin
      @(posedge clk);
      #1;
      chk("ack",      bus.ack,        e_ack);
      chk("wr_en",    bus.rf_wr_en,   e_en);
      chk("wr_sel",   bus.rf_wr_sel,  e_sel);
      chk("wr_data",  bus.rf_wr_data, e_data);
      chk("pending",  bus.pending,    |(bus.req & ~e_ack));
      chk("state",    dbg_state,      e_ack != '0);
      if (bus.rf_wr_en) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL sb_write: got unexpected write x%0d=%0h, expected none", bus.rf_wr_sel, bus.rf_wr_data);
        end else begin
          got = exp_q.pop_front();
          chk("sb_write", {bus.rf_wr_sel, bus.rf_wr_data}, got);
        end
      end
    end
  end

  initial begin : stim
    logic [N-1:0] exp_ack;
    logic [N-1:0] div_seq [6];
    int p1_stage, p1_writes;

    // Reset held with all producers requesting
    bus.req = '1;
    for (int i = 0; i < N; i++) set_p(i, SW'(i + 1), DW'(10 + i));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("rst_ack",  bus.ack, 0);
      chk("rst_en",   bus.rf_wr_en, 0);
      chk("rst_sel",  bus.rf_wr_sel, 0);
      chk("rst_data", bus.rf_wr_data, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_first_ack", bus.ack, 4'b0001);

    // Single request, then dropped
    do_reset();
    set_p(2, 5'd3, 32'd81);
    @(posedge clk); #1;
    chk("single_ack",  bus.ack, 4'b0100);
    chk("single_en",   bus.rf_wr_en, 1);
    chk("single_sel",  bus.rf_wr_sel, 3);
    chk("single_data", bus.rf_wr_data, 81);
    @(negedge clk);
    bus.req = '0;
    @(posedge clk); #1;
    chk("single_idle_en",  bus.rf_wr_en, 0);
    chk("single_hold_sel", bus.rf_wr_sel, 3);

    // Round-robin with all producers re-requesting immediately
    do_reset();
    for (int i = 0; i < N; i++) set_p(i, SW'(i + 1), DW'(200 + i));
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      exp_ack = N'(1 << (k % N));
      chk("rr_ack",   bus.ack, exp_ack);
      chk("rr_model", e_ack, exp_ack);
      chk("rr_en",    bus.rf_wr_en, 1);
      @(negedge clk);
      for (int i = 0; i < N; i++) if (bus.ack[i]) set_p(i, SW'(i + 1), DW'(300 + k));
    end

    // Divider quot/mod pair interleaved with a busy producer 0
    do_reset();
    div_seq[0] = 4'b0001; div_seq[1] = 4'b0010; div_seq[2] = 4'b0001;
    div_seq[3] = 4'b0010; div_seq[4] = 4'b0001; div_seq[5] = 4'b0000;
    p1_stage = 0; p1_writes = 0;
    set_p(0, 5'd1, 32'd100);
    set_p(1, 5'd3, 32'd81);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("div_ack", bus.ack, div_seq[k]);
      if (bus.rf_wr_en && bus.ack[1]) begin
        if (p1_writes == 0) begin
          chk("div_quot_sel", bus.rf_wr_sel, 3);
          chk("div_quot_data", bus.rf_wr_data, 81);
        end else begin
          chk("div_mod_sel", bus.rf_wr_sel, 7);
          chk("div_mod_data", bus.rf_wr_data, 37);
        end
        p1_writes++;
      end
      @(negedge clk);
      if (bus.ack[0]) set_p(0, 5'd1, DW'(101 + k));
      if (bus.ack[1]) begin
        if (p1_stage == 0) begin set_p(1, 5'd7, 32'd37); p1_stage = 1; end
        else bus.req[1] = 1'b0;
      end
    end
    chk("div_count", 64'(p1_writes), 2);

    // Write to x0 is acked but not strobed
    do_reset();
    set_p(1, 5'd0, 32'd5);
    @(posedge clk); #1;
    chk("x0_ack",  bus.ack, 4'b0010);
    chk("x0_en",   bus.rf_wr_en, 0);
    chk("x0_data", bus.rf_wr_data, 5);
    @(negedge clk);
    bus.req = '0;

    // Reset in the cycle of an ack, then re-grant from pointer 0
    do_reset();
    set_p(3, 5'd9, 32'h33);
    @(posedge clk); #1;
    chk("midrst_ack", bus.ack, 4'b1000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ack0", bus.ack, 0);
    chk("midrst_en0",  bus.rf_wr_en, 0);
    @(negedge clk);
    rst = 1'b1;
    set_p(1, 5'd4, 32'h44);
    @(posedge clk); #1;
    chk("midrst_regrant1", bus.ack, 4'b0010);
    @(negedge clk);
    bus.req[1] = 1'b0;
    @(posedge clk); #1;
    chk("midrst_regrant3", bus.ack, 4'b1000);
    @(negedge clk);
    bus.req = '0;

    // Random producers, occasional early drops and resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      for (int i = 0; i < N; i++) begin
        if (bus.req[i] && bus.ack[i]) begin
          if ($urandom_range(0, 1) == 1) set_p(i, SW'($urandom_range(0, 31)), DW'($urandom));
          else bus.req[i] = 1'b0;
        end else if (!bus.req[i]) begin
          if ($urandom_range(0, 2) == 0) set_p(i, SW'($urandom_range(0, 31)), DW'($urandom));
        end else if ($urandom_range(0, 99) == 0) begin
          bus.req[i] = 1'b0;
        end
      end
    end
    @(negedge clk);
    rst     = 1'b1;
    bus.req = '0;
    repeat (3) @(negedge clk);
    chk("sb_drain", 64'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
